// File: rtl/tanh_grad_unit.sv
// tanh backward pass: dx = g * (1 - y*y) in signed Q(INT_SIZE.FRC_SIZE), using one shared
// multiplier sequenced IDLE -> SQR -> MUL -> DONE with valid/ready on both sides.
module tanh_grad_unit #(
    parameter int unsigned INT_SIZE = 3,
    parameter int unsigned FRC_SIZE = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [INT_SIZE+FRC_SIZE-1:0] i_y_in,
    input  logic [INT_SIZE+FRC_SIZE-1:0] i_g_in,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [INT_SIZE+FRC_SIZE-1:0] o_dx_out,
    output logic                         o_sat_flag
);
    localparam int unsigned W = INT_SIZE + FRC_SIZE;
    localparam logic [W:0]   ONE    = (W+1)'(2 ** FRC_SIZE);
    localparam logic [W-1:0] DX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] DX_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

    state_e             r_state;
    logic   [W-1:0]     r_y;
    logic   [W-1:0]     r_g;
    logic   [W-1:0]     r_d;
    logic   [W-1:0]     r_dx;
    logic               r_sat;
    logic               r_sat_flag;
    logic               r_out_valid;

    logic   [W-1:0]     w_op_a;
    logic   [W-1:0]     w_op_b;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W-1:0] w_shift;
    logic   [W-1:0]     w_sq;
    logic   [W:0]       w_d;
    logic               w_fits;
    logic   [W-1:0]     w_dx;

    // Single shared multiplier: y*y while squaring, g*d while scaling.
    assign w_op_a  = (r_state == StSqr) ? r_y : r_g;
    assign w_op_b  = (r_state == StSqr) ? r_y : r_d;
    assign w_prod  = $signed({{W{w_op_a[W-1]}}, w_op_a}) * $signed({{W{w_op_b[W-1]}}, w_op_b});
    assign w_shift = w_prod >>> FRC_SIZE;

    // d is one bit wider so ONE - sq cannot wrap; its MSB is the clamp condition.
    assign w_sq = w_shift[W-1:0];
    assign w_d  = ONE - {w_sq[W-1], w_sq};

    assign w_fits = (&w_shift[2*W-1:W-1]) | ~(|w_shift[2*W-1:W-1]);
    assign w_dx   = w_fits ? w_shift[W-1:0] : (w_shift[2*W-1] ? DX_MIN : DX_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_y         <= '0;
            r_g         <= '0;
            r_d         <= '0;
            r_dx        <= '0;
            r_sat       <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_y     <= i_y_in;
                        r_g     <= i_g_in;
                        r_state <= StSqr;
                    end
                end
                StSqr: begin
                    if (w_d[W]) begin
                        r_d   <= '0;
                        r_sat <= 1'b1;
                    end else begin
                        r_d   <= w_d[W-1:0];
                        r_sat <= 1'b0;
                    end
                    r_state <= StMul;
                end
                StMul: begin
                    r_dx        <= w_dx;
                    r_sat_flag  <= r_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = r_out_valid;
    assign o_dx_out    = r_dx;
    assign o_sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_tanh_grad_unit.sv
// Directed and streaming checks for tanh_grad_unit (Q3.8, W = 11).
module tb_tanh_grad_unit;
    localparam int W = 11;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [W-1:0] i_y;
    logic [W-1:0] i_g;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [W-1:0] o_dx_out;
    logic         o_sat_flag;

    int n_cmp  = 0;
    int n_fail = 0;

    tanh_grad_unit #(.INT_SIZE(3), .FRC_SIZE(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_y_in      (i_y),
        .i_g_in      (i_g),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_dx_out    (o_dx_out),
        .o_sat_flag  (o_sat_flag)
    );

    always #5 i_clk = ~i_clk;

    // Floor-truncation reference for in-range y (no wrap of y*y).
    function automatic logic [W-1:0] ref_dx(input logic [W-1:0] y, input logic [W-1:0] g);
        int yi, gi, sq, d, dx;
        yi = int'($signed(y));
        gi = int'($signed(g));
        sq = (yi * yi) >>> 8;
        d  = 256 - sq;
        if (d < 0) d = 0;
        dx = (gi * d) >>> 8;
        if (dx > 1023) dx = 1023;
        if (dx < -1024) dx = -1024;
        return W'(dx);
    endfunction

    // Runs one transaction from IDLE (called #1 after a rising edge); returns observations.
    task automatic do_txn(input logic [W-1:0] y, input logic [W-1:0] g,
                          output logic [W-1:0] dx, output logic sat, output int lat,
                          output logic busy_ok);
        i_y = y;
        i_g = g;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b0;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!o_out_valid && lat < 10) begin
            if (o_in_ready) busy_ok = 1'b0;
            @(posedge i_clk); #1;
            lat++;
        end
        if (o_in_ready) busy_ok = 1'b0;
        dx  = o_dx_out;
        sat = o_sat_flag;
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_out_ready = 1'b0;
        i_y = '0;
        i_g = '0;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b want=1", o_in_ready);
        end
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_dx_out !== 11'h000 || o_sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b dx=%h sat=%b want 0/000/0",
                     o_out_valid, o_dx_out, o_sat_flag);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] dx;
        logic sat, busy_ok;
        int lat;
        do_txn(11'h000, 11'h0C0, dx, sat, lat, busy_ok);
        n_cmp++;
        if (dx !== 11'h0C0 || sat !== 1'b0) begin
            n_fail++; $display("FAIL basic_dx got=%h/%b want=0c0/0", dx, sat);
        end
        n_cmp++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL basic_latency got=%0d want=2", lat);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_fail++; $display("FAIL basic_in_ready_busy got in_ready high while busy want low");
        end
    endtask

    task automatic test_symmetry();
        logic [W-1:0] ys [4] = '{11'h080, 11'h780, 11'h080, 11'h080};
        logic [W-1:0] gs [4] = '{11'h100, 11'h100, 11'h700, 11'h7FF};
        logic [W-1:0] es [4] = '{11'h0C0, 11'h0C0, 11'h740, 11'h7FF};
        logic [W-1:0] dx;
        logic sat, busy_ok;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_txn(ys[i], gs[i], dx, sat, lat, busy_ok);
            n_cmp++;
            if (dx !== es[i] || sat !== 1'b0) begin
                n_fail++;
                $display("FAIL symmetry_%0d y=%h g=%h got=%h/%b want=%h/0",
                         i, ys[i], gs[i], dx, sat, es[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ys [3] = '{11'h100, 11'h180, 11'h001};
        logic [W-1:0] gs [3] = '{11'h2FF, 11'h100, 11'h100};
        logic [W-1:0] es [3] = '{11'h000, 11'h000, 11'h100};
        logic         ss [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] dx;
        logic sat, busy_ok;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_txn(ys[i], gs[i], dx, sat, lat, busy_ok);
            n_cmp++;
            if (dx !== es[i] || sat !== ss[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d y=%h g=%h got=%h/%b want=%h/%b",
                         i, ys[i], gs[i], dx, sat, es[i], ss[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        i_y = 11'h080;
        i_g = 11'h100;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b0;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        lat = 0;
        while (!o_out_valid && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            i_y = W'($urandom_range(0, 2047));
            i_g = W'($urandom_range(0, 2047));
            i_in_valid = (i % 2 == 0);
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_dx_out !== 11'h0C0 || o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d got dx=%h v=%b rdy=%b want 0c0/1/0",
                         i, o_dx_out, o_out_valid, o_in_ready);
            end
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release got v=%b rdy=%b want 0/1", o_out_valid, o_in_ready);
        end
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_no_second got v=%b rdy=%b want 0/1", o_out_valid, o_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] dx;
        logic sat, busy_ok;
        int lat;
        i_y = 11'h000;
        i_g = 11'h1A0;
        i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_dx_out !== 11'h000 || o_sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got v=%b dx=%h sat=%b want 0/000/0",
                     o_out_valid, o_dx_out, o_sat_flag);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        n_cmp++;
        if (o_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_in_ready got=%b want=1", o_in_ready);
        end
        do_txn(11'h080, 11'h100, dx, sat, lat, busy_ok);
        n_cmp++;
        if (dx !== 11'h0C0 || lat !== 2) begin
            n_fail++; $display("FAIL reset_mid_next got dx=%h lat=%0d want 0c0/2", dx, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ys [20];
        logic [W-1:0] gs [20];
        logic [W-1:0] es [20];
        int acc, got, cyc, last;
        logic rdy;
        for (int i = 0; i < 20; i++) begin
            int yi;
            yi = int'($urandom_range(0, 384));
            if ($urandom_range(0, 1) == 1) yi = -yi;
            ys[i] = W'(yi);
            gs[i] = W'($urandom_range(0, 2047));
            es[i] = ref_dx(ys[i], gs[i]);
        end
        acc = 0; got = 0; cyc = 0; last = 0;
        i_out_ready = 1'b1;
        while (got < 20 && cyc < 400) begin
            if (acc < 20) begin
                i_y = ys[acc];
                i_g = gs[acc];
                i_in_valid = 1'b1;
            end else begin
                i_in_valid = 1'b0;
            end
            rdy = o_in_ready;
            @(posedge i_clk); #1;
            cyc++;
            if (rdy && acc < 20) begin
                if (acc > 0) begin
                    n_cmp++;
                    if (cyc - last !== 4) begin
                        n_fail++;
                        $display("FAIL stream_spacing_%0d got=%0d want=4", acc, cyc - last);
                    end
                end
                last = cyc;
                acc++;
            end
            if (o_out_valid) begin
                n_cmp++;
                if (o_dx_out !== es[got]) begin
                    n_fail++;
                    $display("FAIL stream_dx_%0d y=%h g=%h got=%h want=%h",
                             got, ys[got], gs[got], o_dx_out, es[got]);
                end
                got++;
            end
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        n_cmp++;
        if (got !== 20) begin
            n_fail++; $display("FAIL stream_count got=%0d want=20", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_symmetry();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tanh_grad_unit.md
# tanh_grad_unit

Backward-pass companion to the forward tanh activation in the one-block NN datapath. It takes a stored forward activation y = tanh(x) and an upstream gradient g, and returns the input gradient dx = g·(1 − y²). Both operands and the result use the same signed Q(INT_SIZE.FRC_SIZE) fixed-point format as the forward path. One shared W×W multiplier is time-multiplexed by a small FSM, with valid/ready handshakes on both sides.

## Interface
- INT_SIZE, 3, integer bits including sign
- FRC_SIZE, 8, fractional bits; W = INT_SIZE+FRC_SIZE, ONE = 1<<FRC_SIZE
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  y_in/g_in valid
- in_ready  out  1  unit accepts input (high only in IDLE)
- y_in  in  W  forward activation y, signed Q format
- g_in  in  W  upstream gradient g, signed Q format
- out_valid  out  1  dx_out valid
- out_ready  in  1  downstream accepts result
- dx_out  out  W  input gradient, signed Q format
- sat_flag  out  1  qualifies dx_out: 1 means (1 − y²) was clamped to 0 because |y| > 1

## Operation
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register y_in → y_r and g_r, then go to SQR.
- SQR:
  - Multiplier computes y_r·y_r (2W-bit signed product).
  - sq = product >>> FRC_SIZE, truncated to W bits.
  - d = ONE − sq.
  - If d < 0, set d_r = 0 and sat_r = 1. Otherwise d_r = d and sat_r = 0.
  - Go to MUL.
- MUL:
  - Multiplier computes g_r·d_r.
  - dx = product >>> FRC_SIZE. The arithmetic shift floors toward −inf.
  - Saturate dx to the W-bit signed range. This cannot trigger when d_r ∈ [0, ONE], but the guard is required.
  - Register dx → dx_out and sat_r → sat_flag, then go to DONE.
- DONE:
  - out_valid = 1.
  - dx_out and sat_flag hold stable until out_ready.
  - On out_ready, go to IDLE.
- Multiplier sharing:
  - Exactly one W×W signed multiplier.
  - Operand muxes are selected by state.
- Input sampling:
  - Inputs are sampled only on the accept edge.
  - Changes on y_in/g_in at any other time have no effect.
- Reset (rst_n low), at any time including mid-operation:
  - state = IDLE; y_r, g_r, d_r, dx_out = 0; sat_flag = 0; out_valid = 0.
  - in_ready = 1 (it is decoded from state).
  - An in-flight transaction is discarded with no output.

## Timing
- Accept at edge k.
- SQR during cycle k..k+1; d_r captured at edge k+1.
- MUL during cycle k+1..k+2; dx_out captured at edge k+2.
- out_valid high from edge k+2; latency is 2 cycles accept-to-valid.
- With out_ready held high, DONE lasts one cycle: IDLE again after edge k+3, next accept possible at edge k+4. Minimum spacing is 4 cycles per sample.
- in_ready and out_valid are never high in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0.
- out_valid, dx_out and sat_flag are registered (glitch-free). in_ready is a state decode, with no combinational path from any input.

## Test plan
- Reset, then y=0x000, g=0x0C0 (0.75):
  - d = 256; dx_out = 0x0C0 and sat_flag = 0 with out_valid exactly 2 cycles after accept.
  - Check that in_ready stays 0 during SQR/MUL/DONE.
- Even symmetry and flooring, g = 0x100:
  - y=0x080 gives sq = 64, d = 192, dx = 0x0C0; y=0x780 (−0.5) gives an identical result.
  - y=0x080, g=0x700 (−1.0) gives dx = 0x740 (−0.75).
  - y=0x080, g=0x7FF gives dx = 0x7FF (−192>>>8 floors to −1).
- Boundaries:
  - y=0x100 (1.0), g=0x2FF gives dx = 0x000, sat_flag = 0.
  - y=0x180 (1.5), g=0x100 gives d clamped, dx = 0x000, sat_flag = 1.
  - y=0x001, g=0x100 gives sq = 0, dx = 0x100.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles while toggling y_in/g_in and in_valid.
  - Required: dx_out is constant, out_valid stays 1, no second accept.
  - Release out_ready: one transfer occurs, then in_ready = 1 the following cycle.
- Reset mid-operation:
  - Assert rst_n low during MUL.
  - Required immediately (asynchronous): out_valid = 0, dx_out = 0, sat_flag = 0.
  - After release, in_ready = 1 and the next transaction (y=0x080, g=0x100) returns 0x0C0.
- Back-to-back streaming with in_valid and out_ready tied high over 20 random in-range pairs:
  - Accepts occur every 4 cycles.
  - Every output matches a floor-truncation reference model, in order.
